// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM Avalon-MM burst responder.
// The LFSR constants are only consumed when SDRAM_RESP_BACKPRESSURE_EN is defined.
package sdram_pkg;

  localparam int DEF_SDRAM_DATA_W = 128;
  localparam int DEF_SDRAM_ADDR_W = 32;

  function automatic int byte_en_w(input int data_w);
    return data_w / 8;
  endfunction

  localparam int BYTE_EN_W = byte_en_w(DEF_SDRAM_DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_BURST
  } resp_state_e;

  // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0].
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/sdram_avmm_responder_if.sv
// Avalon-MM burst bus between the rf_ldst initiator (master) and the SDRAM port
// responder (slave).
interface sdram_avmm_responder_if
  import sdram_pkg::*;
#(
  parameter int DATA_W  = DEF_SDRAM_DATA_W,
  parameter int ADDR_W  = DEF_SDRAM_ADDR_W,
  parameter int BURST_W = 11
) ();

  localparam int BE_W = byte_en_w(DATA_W);

  logic [ADDR_W-1:0]  avs_address;
  logic               avs_read;
  logic               avs_write;
  logic [DATA_W-1:0]  avs_writedata;
  logic [BE_W-1:0]    avs_byteenable;
  logic [BURST_W-1:0] avs_burstcount;
  logic               avs_waitrequest;
  logic [DATA_W-1:0]  avs_readdata;
  logic               avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
           avs_burstcount,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
           avs_burstcount,
    output avs_waitrequest, avs_readdata, avs_readdatavalid
  );

endinterface

// File: rtl/be_sp_ram.sv
// Single-port write-first RAM with per-byte write enables and 1-cycle read latency.
// A write also returns the merged word on rdata.
module be_sp_ram
  import sdram_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = DEF_SDRAM_DATA_W
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [byte_en_w(DATA_W)-1:0] be,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  localparam int BE_W = byte_en_w(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] merged;

  always_comb begin
    merged = mem[addr];
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM; clearing it would
  // force a flop implementation and a DEPTH-cycle init sequence.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= merged;
      rdata <= we ? merged : mem[addr];
    end
  end

endmodule

// File: rtl/sdram_avmm_responder.sv
// Avalon-MM burst responder backed by an on-chip byte-enabled RAM window.
// Optional random stalls in IDLE/WR_BURST: define SDRAM_RESP_BACKPRESSURE_EN.
module sdram_avmm_responder
  import sdram_pkg::*;
#(
  parameter int SDRAM_DATA_W = DEF_SDRAM_DATA_W,
  parameter int SDRAM_ADDR_W = DEF_SDRAM_ADDR_W,
  parameter int BURST_W      = 11,
  parameter int MEM_DEPTH    = 4096,
  parameter logic [SDRAM_ADDR_W-1:0] BASE_ADDR = 32'h2000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sdram_avmm_responder_if.slave bus,
  output logic                  resp_err
);

  localparam int BE_W  = byte_en_w(SDRAM_DATA_W);
  localparam int LSB_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [SDRAM_ADDR_W-1:0] SPAN       = SDRAM_ADDR_W'(MEM_DEPTH * BE_W);
  localparam logic [SDRAM_ADDR_W-1:0] BEAT_BYTES = SDRAM_ADDR_W'(BE_W);
  localparam logic [BURST_W-1:0]      ONE        = BURST_W'(1);

  resp_state_e             state_q, state_d;
  logic [SDRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [BURST_W-1:0]      rem_q, rem_d;
  logic [BURST_W-1:0]      bc_eff;
  logic [SDRAM_ADDR_W-1:0] beat_addr, beat_off;
  logic [IDX_W-1:0]        ram_idx;
  logic                    beat_win;
  logic                    wr_acc, rd_issue;
  logic                    ram_en;
  logic                    stall, waitreq;
  logic                    rd_valid_q, rd_win_q;
  logic [SDRAM_DATA_W-1:0] ram_rdata, rdata_hold_q, readdata;

`ifdef SDRAM_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign stall = (lfsr_q[1:0] == 2'b00) && (state_q != RD_BURST);
`else
  assign stall = 1'b0;
`endif

  // Reset must hold the initiator off combinationally, not one cycle late.
  assign waitreq = !rst_n || (state_q == RD_BURST) || stall;
  assign bus.avs_waitrequest = waitreq;

  assign bc_eff   = (bus.avs_burstcount == '0) ? ONE : bus.avs_burstcount;
  assign beat_off = beat_addr - BASE_ADDR;
  assign beat_win = (beat_addr >= BASE_ADDR) && (beat_off < SPAN);
  assign ram_idx  = beat_off[LSB_W +: IDX_W];
  assign ram_en   = (wr_acc || rd_issue) && beat_win;

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    beat_addr = addr_q;
    wr_acc    = 1'b0;
    rd_issue  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A simultaneous read is a protocol violation; the write wins.
        if (bus.avs_write && !waitreq) begin
          beat_addr = bus.avs_address;
          wr_acc    = 1'b1;
          addr_d    = bus.avs_address + BEAT_BYTES;
          rem_d     = bc_eff - ONE;
          if (bc_eff != ONE) state_d = WR_BURST;
        end else if (bus.avs_read && !waitreq) begin
          beat_addr = bus.avs_address;
          rd_issue  = 1'b1;
          addr_d    = bus.avs_address + BEAT_BYTES;
          rem_d     = bc_eff - ONE;
          if (bc_eff != ONE) state_d = RD_BURST;
        end
      end
      WR_BURST: begin
        if (bus.avs_write && !waitreq) begin
          wr_acc = 1'b1;
          addr_d = addr_q + BEAT_BYTES;
          rem_d  = rem_q - ONE;
          if (rem_q == ONE) state_d = IDLE;
        end
      end
      RD_BURST: begin
        rd_issue = 1'b1;
        addr_d   = addr_q + BEAT_BYTES;
        rem_d    = rem_q - ONE;
        if (rem_q == ONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      rd_valid_q   <= 1'b0;
      rd_win_q     <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      rd_valid_q   <= rd_issue;
      rd_win_q     <= beat_win;
      rdata_hold_q <= readdata;
    end
  end

  be_sp_ram #(
    .DEPTH  (MEM_DEPTH),
    .DATA_W (SDRAM_DATA_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (wr_acc),
    .addr  (ram_idx),
    .be    (bus.avs_byteenable),
    .wdata (bus.avs_writedata),
    .rdata (ram_rdata)
  );

  // Out-of-window beats read as zero; idle cycles hold the last returned beat.
  assign readdata = rd_valid_q ? (rd_win_q ? ram_rdata : '0) : rdata_hold_q;

  assign bus.avs_readdata      = readdata;
  assign bus.avs_readdatavalid = rd_valid_q;
  assign resp_err = (rd_valid_q && !rd_win_q) || (wr_acc && !beat_win);

endmodule
